reflex_sequencer: RTL
=====================

# reflex_sequencer

Game-flow controller for the NinjaReflex move-matching datapath. It walks the current level's 60-bit action pattern one 4-bit move at a time and edge-detects the four debounced buttons. It also times each move, counts mistakes, and advances through levels until the player wins or exceeds the mistake limit. It sits between the button debouncers, the level pattern ROM (addressed by `level_num`), and the display/score logic.

## Interface
- `TIMEOUT_CYCLES`, 250000000, cycles allowed per move (5 s at 50 MHz); must be ≥ 2
- `TIMER_W`, 28, timer width; must hold `TIMEOUT_CYCLES-1`
- `MOVES`, 15, moves per level (1..15); pattern occupies bits `[4*MOVES-1:0]`
- `NUM_LEVELS`, 4, levels per game (1..8)
- `MAX_WRONG`, 3, mistakes that end the game (1..255)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins or restarts a game from IDLE/OVER/WIN
- `btn`  in  4  debounced level buttons; codes btn[0]=4'b0011, btn[1]=4'b0010, btn[2]=4'b0001, btn[3]=4'b0000
- `action`  in  60  pattern for `level_num`; move k = `action[4k+3:4k]`
- `level_num`  out  3  current level index, 0-based
- `count`  out  8  bit offset of current move (0,4,…,4*(MOVES-1))
- `playing`  out  1  high in PLAY and RELEASE
- `operation`  out  4  code of last accepted press
- `wrong_time`  out  8  mistakes this game
- `hit`  out  1  one-cycle pulse, correct press accepted
- `game_over`  out  1  high in OVER
- `win`  out  1  high in WIN

## Operation
- States: IDLE, PLAY, RELEASE, NEXT, OVER, WIN. Reset → IDLE, all outputs 0.
- IDLE/OVER/WIN + `start`: `level_num`=0, `count`=0, `wrong_time`=0, `operation`=0, timer=0 → PLAY.
- Button press = rising edge of any `btn` bit against a registered copy of `btn` (the copy updates every cycle, including in reset, where it is cleared). Priority on simultaneous edges: btn[0] > btn[1] > btn[2] > btn[3].
- PLAY, press: `operation`←code. If code ≠ current move, `wrong_time`+1; otherwise `hit` pulses. Timer cleared → RELEASE.
- PLAY, no press, timer = `TIMEOUT_CYCLES-1`: see Configuration.
- RELEASE: waits for `btn`==0. Then, if `wrong_time` ≥ `MAX_WRONG` → OVER; else if `count`==4*(MOVES-1) → NEXT; else `count`+4 → PLAY.
- NEXT (1 cycle): if `level_num`==NUM_LEVELS-1 → WIN; else `level_num`+1, `count`=0, timer=0 → PLAY.
- Presses are ignored outside PLAY; a button held from RELEASE into PLAY is not a press.
- `wrong_time` saturates at 255. The OVER check uses the updated value.
- `start` in PLAY/RELEASE/NEXT is ignored.

## Timing
- The press edge is seen one cycle after the `btn` change. `operation`, `wrong_time`, and `hit` update on the following edge, and the state enters RELEASE at the same edge. Press-to-result latency is 2 cycles from the `btn` input change.
- RELEASE exit happens one cycle after `btn`==0 is sampled.
- The timer counts only in PLAY. It resets on entry to PLAY and on every accepted press.
- `action` must be stable from the NEXT cycle onward. The ROM has one cycle to follow `level_num`; the first comparison occurs ≥ 2 cycles after the `level_num` change.
- `rst_n` low in any state: the next edge returns to IDLE with all outputs 0, and the in-progress game is lost.

## Configuration
- `REFLEX_TIMEOUT_EN` defined: a PLAY timeout counts as a mistake. `wrong_time`+1, `operation` unchanged, no `hit`. The block then advances exactly as RELEASE would with `btn`==0: the OVER check, then NEXT, or `count`+4 → PLAY with timer=0.
- Undefined: the timer logic is not built. PLAY waits indefinitely for a press.

## Test plan
Use MOVES=3, NUM_LEVELS=2, MAX_WRONG=2, TIMEOUT_CYCLES=20, and pattern moves 0011,0001,0000.
- Reset then `start`; press btn0, btn2, btn3 on level 0, then repeat on level 1 → 6 `hit` pulses, `count` 0→4→8, `level_num` 0→1, `win`=1, `wrong_time`=0.
- Press btn1 on move 0 → `operation`=0010, `wrong_time`=1, no `hit`, `count` stays 0 until release then becomes 4.
- Raise btn0 and btn3 on the same cycle on move 0 → btn0 wins, `operation`=0011, `hit`=1.
- Hold btn0 across the move-0 → move-1 transition → no second press registered; `wrong_time` is unchanged until btn0 is released and pressed again.
- With `REFLEX_TIMEOUT_EN`, idle for 20 cycles in PLAY twice → `wrong_time`=2, `game_over`=1. Without the macro, 100 idle cycles → still PLAY, `wrong_time`=0.
- Assert `rst_n`=0 in RELEASE of level 1 → next cycle IDLE, all outputs 0. A subsequent `start` begins at `level_num`=0.

Source files
------------

// File: rtl/reflex_sequencer_if.sv
// Bundle of game-flow signals between the reflex sequencer and its environment.
// The master side is the sequencer; the slave side is the buttons, pattern ROM and display.
interface reflex_sequencer_if;
   logic        start;
   logic [3:0]  btn;
   logic [59:0] action;
   logic [2:0]  level_num;
   logic [7:0]  count;
   logic        playing;
   logic [3:0]  operation;
   logic [7:0]  wrong_time;
   logic        hit;
   logic        game_over;
   logic        win;

   modport master (
      input  start, btn, action,
      output level_num, count, playing, operation, wrong_time, hit, game_over, win
   );

   modport slave (
      output start, btn, action,
      input  level_num, count, playing, operation, wrong_time, hit, game_over, win
   );
endinterface

// File: rtl/reflex_sequencer.sv
// NinjaReflex game-flow controller: walks the level pattern, scores button presses, advances levels.
// Optional per-move timeout enabled by defining REFLEX_TIMEOUT_EN.
module reflex_sequencer #(
   parameter int TIMEOUT_CYCLES = 250000000,
   parameter int TIMER_W        = 28,
   parameter int MOVES          = 15,
   parameter int NUM_LEVELS     = 4,
   parameter int MAX_WRONG      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   reflex_sequencer_if.master bus
);

   if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES - 1) >= (64'd1 << TIMER_W)) begin : g_bad_timer_cfg
      $error("reflex_sequencer: TIMER_W cannot hold TIMEOUT_CYCLES-1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_RELEASE, S_NEXT, S_OVER, S_WIN
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(4 * (MOVES - 1));
   localparam logic [2:0] LAST_LVL = 3'(NUM_LEVELS - 1);
   localparam logic [7:0] MAX_W    = 8'(MAX_WRONG);

   state_t     state_q, state_d;
   logic [3:0] btn_q, press_q;
   logic [2:0] level_q, level_d;
   logic [7:0] count_q, count_d;
   logic [3:0] op_q, op_d;
   logic [7:0] wrong_q, wrong_d;
   logic       hit_q, hit_d;

   logic       press_vld;
   logic [3:0] press_code;
   logic [3:0] cur_move;
   logic [7:0] wrong_inc;
   logic [7:0] adv_wrong;
   logic       adv_go;
   logic       timeout;

   assign press_vld = |press_q;
   assign cur_move  = bus.action[count_q[5:0] +: 4];
   assign wrong_inc = (wrong_q == 8'hFF) ? wrong_q : wrong_q + 8'd1;

   always_comb begin
      press_code = 4'b0000;
      if (press_q[0])      press_code = 4'b0011;
      else if (press_q[1]) press_code = 4'b0010;
      else if (press_q[2]) press_code = 4'b0001;
   end

`ifdef REFLEX_TIMEOUT_EN
   logic [TIMER_W-1:0] timer_q, timer_d;

   assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

   // Held at zero outside PLAY, so every entry into PLAY starts a fresh move window.
   always_comb begin
      timer_d = '0;
      if (state_q == S_PLAY && !press_vld && !timeout) timer_d = timer_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // A timeout finishes the move the same way a release does, but with the mistake counted.
   assign adv_go    = (state_q == S_RELEASE && btn_q == 4'b0000) ||
                      (state_q == S_PLAY && !press_vld && timeout);
   assign adv_wrong = (state_q == S_RELEASE) ? wrong_q : wrong_inc;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      count_d = count_q;
      op_d    = op_q;
      wrong_d = wrong_q;
      hit_d   = 1'b0;
      case (state_q)
         S_IDLE, S_OVER, S_WIN: begin
            if (bus.start) begin
               level_d = '0;
               count_d = '0;
               wrong_d = '0;
               op_d    = '0;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (press_vld) begin
               op_d = press_code;
               if (press_code != cur_move) wrong_d = wrong_inc;
               else                        hit_d   = 1'b1;
               state_d = S_RELEASE;
            end else if (timeout) begin
               wrong_d = wrong_inc;
            end
         end
         S_RELEASE: ;
         S_NEXT: begin
            if (level_q == LAST_LVL) begin
               state_d = S_WIN;
            end else begin
               level_d = level_q + 3'd1;
               count_d = '0;
               state_d = S_PLAY;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv_go) begin
         if (adv_wrong >= MAX_W)       state_d = S_OVER;
         else if (count_q == LAST_CNT) state_d = S_NEXT;
         else begin
            count_d = count_q + 8'd4;
            state_d = S_PLAY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         btn_q   <= '0;
         press_q <= '0;
         level_q <= '0;
         count_q <= '0;
         op_q    <= '0;
         wrong_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         btn_q   <= bus.btn;
         press_q <= bus.btn & ~btn_q;
         level_q <= level_d;
         count_q <= count_d;
         op_q    <= op_d;
         wrong_q <= wrong_d;
         hit_q   <= hit_d;
      end
   end

   assign bus.level_num  = level_q;
   assign bus.count      = count_q;
   assign bus.playing    = (state_q == S_PLAY) || (state_q == S_RELEASE);
   assign bus.operation  = op_q;
   assign bus.wrong_time = wrong_q;
   assign bus.hit        = hit_q;
   assign bus.game_over  = (state_q == S_OVER);
   assign bus.win        = (state_q == S_WIN);

endmodule
